jtag_dtm_sequencer: RTL and testbench



---
 rtl/jtag_seq_pkg.sv | 32 +++
 rtl/jtag_tck_gen.sv | 39 +++
 rtl/jtag_dtm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_jtag_dtm_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_seq_pkg.sv
// Shared types and constants for the JTAG DTM scan sequencer: FSM states,
// TAP header/tail TMS patterns (bit i = TMS for TCK period i) and DTM IR opcodes.
package jtag_seq_pkg;

   typedef enum logic [3:0] {
      ST_TAP_RST   = 4'd0,
      ST_IDLE      = 4'd1,
      ST_IR_HDR    = 4'd2,
      ST_IR_SHIFT  = 4'd3,
      ST_IR_TAIL   = 4'd4,
      ST_DR_HDR    = 4'd5,
      ST_DR_SHIFT  = 4'd6,
      ST_DR_TAIL   = 4'd7,
      ST_IDLE_WAIT = 4'd8,
      ST_RSP       = 4'd9
   } seq_state_t;

   // Five periods in Test-Logic-Reset, then one into Run-Test/Idle
   localparam logic [7:0] RST_TMS    = 8'b0001_1111;
   localparam int         RST_LEN    = 6;
   localparam logic [7:0] IR_HDR_TMS = 8'b0000_0011;
   localparam int         IR_HDR_LEN = 4;
   localparam logic [7:0] DR_HDR_TMS = 8'b0000_0001;
   localparam int         DR_HDR_LEN = 3;
   localparam logic [7:0] TAIL_TMS   = 8'b0000_0001;
   localparam int         TAIL_LEN   = 2;

   localparam logic [4:0] IR_IDCODE  = 5'h01;
   localparam logic [4:0] IR_DTMCS   = 5'h10;
   localparam logic [4:0] IR_DMI     = 5'h11;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles tck every CLK_DIV clocks while run is high, held low otherwise.
// tck_rise/tck_fall flag the clock on which tck is about to go high/low.
module jtag_tck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic tck,
   output logic tck_rise,
   output logic tck_fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] div_cnt_r;
   logic          tck_r;
   logic          terminal_s;

   assign terminal_s = run && (div_cnt_r == CW'(CLK_DIV - 1));
   assign tck_rise   = terminal_s && !tck_r;
   assign tck_fall   = terminal_s && tck_r;
   assign tck        = tck_r;

   // Divider counter and TCK register
   always_ff @(posedge clock) begin
      if (reset || !run) begin
         div_cnt_r <= {CW{1'b0}};
         tck_r     <= 1'b0;
      end else if (terminal_s) begin
         div_cnt_r <= {CW{1'b0}};
         tck_r     <= ~tck_r;
      end else begin
         div_cnt_r <= div_cnt_r + CW'(1'b1);
         tck_r     <= tck_r;
      end
   end

endmodule

// File: rtl/jtag_dtm_sequencer.sv
// Bit-level JTAG master: one command = optional IR scan then DR scan, captured TDO returned.
// Optional macro JTAG_SEQ_IDLE_CYCLES_EN adds IDLE_CYCLES Run-Test/Idle periods after each DR scan.
module jtag_dtm_sequencer
   import jtag_seq_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int IR_LEN  = 5,
   parameter int DR_MAX  = 41,
   parameter int LEN_W   = 6
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
   , parameter int IDLE_CYCLES = 5
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_skip_ir,
   input  logic [IR_LEN-1:0] cmd_ir,
   input  logic [DR_MAX-1:0] cmd_dr,
   input  logic [LEN_W-1:0]  cmd_dr_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DR_MAX-1:0] rsp_dr,
   output logic              busy,
   output logic              jtag_TCK,
   output logic              jtag_TMS,
   output logic              jtag_TDI,
   input  logic              jtag_TDO
);

   seq_state_t        state_r, state_nx_s, after_s;
   logic [LEN_W-1:0]  cnt_r, cnt_nx_s, end_s, len_r, len_clamp_s;
   logic [IR_LEN-1:0] ir_r;
   logic [DR_MAX-1:0] dr_r, rsp_dr_r;
   logic              tms_r, tdi_r, cmd_ready_r, rsp_valid_r, busy_r;
   logic              accept_s, run_s, tck_rise_s, tck_fall_s, tms_s, tdi_s;
   logic [7:0]        seq_s;

   assign len_clamp_s = (cmd_dr_len > LEN_W'(DR_MAX)) ? LEN_W'(DR_MAX) : cmd_dr_len;
   assign run_s       = (state_r != ST_IDLE) && (state_r != ST_RSP);

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clock    (clock),
      .reset    (reset),
      .run      (run_s),
      .tck      (jtag_TCK),
      .tck_rise (tck_rise_s),
      .tck_fall (tck_fall_s)
   );

   // Per-state period count and successor; state/period advance on each TCK fall
   always_comb begin
      end_s      = {LEN_W{1'b0}};
      after_s    = ST_IDLE;
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      accept_s   = 1'b0;
      case (state_r)
         ST_TAP_RST:  begin end_s = LEN_W'(RST_LEN - 1);    after_s = ST_IDLE;     end
         ST_IR_HDR:   begin end_s = LEN_W'(IR_HDR_LEN - 1); after_s = ST_IR_SHIFT; end
         ST_IR_SHIFT: begin end_s = LEN_W'(IR_LEN - 1);     after_s = ST_IR_TAIL;  end
         ST_IR_TAIL:  begin
            end_s   = LEN_W'(TAIL_LEN - 1);
            after_s = (len_r != {LEN_W{1'b0}}) ? ST_DR_HDR : ST_RSP;
         end
         ST_DR_HDR:   begin end_s = LEN_W'(DR_HDR_LEN - 1); after_s = ST_DR_SHIFT; end
         ST_DR_SHIFT: begin end_s = len_r - LEN_W'(1'b1);   after_s = ST_DR_TAIL;  end
         ST_DR_TAIL:  begin
            end_s   = LEN_W'(TAIL_LEN - 1);
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
            after_s = ST_IDLE_WAIT;
`else
            after_s = ST_RSP;
`endif
         end
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
         ST_IDLE_WAIT: begin end_s = LEN_W'(IDLE_CYCLES - 1); after_s = ST_RSP; end
`endif
         default:     begin end_s = {LEN_W{1'b0}}; after_s = ST_IDLE; end
      endcase

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               accept_s   = 1'b1;
               cnt_nx_s   = {LEN_W{1'b0}};
               state_nx_s = !cmd_skip_ir ? ST_IR_HDR :
                            (len_clamp_s == {LEN_W{1'b0}}) ? ST_RSP : ST_DR_HDR;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RSP: state_nx_s = rsp_ready ? ST_IDLE : ST_RSP;
         default: begin
            if (tck_fall_s && (cnt_r == end_s)) begin
               state_nx_s = after_s;
               cnt_nx_s   = {LEN_W{1'b0}};
            end else if (tck_fall_s) begin
               cnt_nx_s   = cnt_r + LEN_W'(1'b1);
            end else begin
               cnt_nx_s   = cnt_r;
            end
         end
      endcase
   end

   // TMS/TDI for the period about to start, so pins only move on a fall or state entry
   always_comb begin
      seq_s = 8'h00;
      tms_s = 1'b0;
      tdi_s = 1'b0;
      case (state_nx_s)
         ST_TAP_RST: begin seq_s = RST_TMS;    tms_s = seq_s[cnt_nx_s[2:0]]; end
         ST_IR_HDR:  begin seq_s = IR_HDR_TMS; tms_s = seq_s[cnt_nx_s[2:0]]; end
         ST_DR_HDR:  begin seq_s = DR_HDR_TMS; tms_s = seq_s[cnt_nx_s[2:0]]; end
         ST_IR_TAIL, ST_DR_TAIL: begin
            seq_s = TAIL_TMS;
            tms_s = seq_s[cnt_nx_s[2:0]];
         end
         ST_IR_SHIFT: begin
            tms_s = (cnt_nx_s == LEN_W'(IR_LEN - 1));
            tdi_s = |(ir_r & (IR_LEN'(1'b1) << cnt_nx_s));
         end
         ST_DR_SHIFT: begin
            tms_s = (cnt_nx_s == (len_r - LEN_W'(1'b1)));
            tdi_s = |(dr_r & (DR_MAX'(1'b1) << cnt_nx_s));
         end
         default: begin tms_s = 1'b0; tdi_s = 1'b0; end
      endcase
   end

   // State, latched command, pin and handshake registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_TAP_RST;
         cnt_r       <= {LEN_W{1'b0}};
         ir_r        <= {IR_LEN{1'b0}};
         dr_r        <= {DR_MAX{1'b0}};
         len_r       <= {LEN_W{1'b0}};
         tms_r       <= 1'b1;
         tdi_r       <= 1'b0;
         cmd_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b1;
         rsp_dr_r    <= {DR_MAX{1'b0}};
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         tms_r       <= tms_s;
         tdi_r       <= tdi_s;
         cmd_ready_r <= (state_nx_s == ST_IDLE);
         rsp_valid_r <= (state_nx_s == ST_RSP);
         busy_r      <= (state_nx_s != ST_IDLE);
         if (accept_s) begin
            ir_r     <= cmd_ir;
            dr_r     <= cmd_dr;
            len_r    <= len_clamp_s;
            rsp_dr_r <= {DR_MAX{1'b0}};
         end else if ((state_r == ST_DR_SHIFT) && tck_rise_s) begin
            rsp_dr_r <= rsp_dr_r | (DR_MAX'(jtag_TDO) << cnt_r);
         end else begin
            rsp_dr_r <= rsp_dr_r;
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_dr    = rsp_dr_r;
   assign busy      = busy_r;
   assign jtag_TMS  = tms_r;
   assign jtag_TDI  = tdi_r;

endmodule

// File: tb/tb_jtag_dtm_sequencer.sv
// Scoreboard bench for jtag_dtm_sequencer: a behavioural TAP target observes TMS/TDI
// and supplies TDO; expected responses are queued at command time and checked on response.
module tb_jtag_dtm_sequencer;
   import jtag_seq_pkg::*;

   localparam int CLK_DIV = 2;
   localparam int IR_LEN  = 5;
   localparam int DR_MAX  = 41;
   localparam int LEN_W   = 6;
   localparam int PERIOD  = 2 * CLK_DIV * 10;

   localparam int T_TLR = 0, T_RTI = 1, T_SELDR = 2, T_CAPDR = 3, T_SHDR = 4, T_EX1DR = 5,
                  T_PSDR = 6, T_EX2DR = 7, T_UPDR = 8, T_SELIR = 9, T_CAPIR = 10,
                  T_SHIR = 11, T_EX1IR = 12, T_PSIR = 13, T_EX2IR = 14, T_UPIR = 15;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid = 1'b0, cmd_skip_ir = 1'b0, rsp_ready = 1'b0;
   logic [IR_LEN-1:0] cmd_ir = '0;
   logic [DR_MAX-1:0] cmd_dr = '0;
   logic [LEN_W-1:0]  cmd_dr_len = '0;
   logic              cmd_ready, rsp_valid, busy, jtag_TCK, jtag_TMS, jtag_TDI;
   logic              jtag_TDO = 1'b0;
   logic [DR_MAX-1:0] rsp_dr;

   typedef struct {
      logic [DR_MAX-1:0] rsp;
      logic [4:0]        ir;
      logic [63:0]       dr_in;
      int                len;
      int                rises;
      int                irn;
      bit                skip;
   } exp_t;
   exp_t sb_q[$];

   int vectors = 0, miscompares = 0;

   // target TAP model state
   int          tap_st = T_TLR;
   int          rise_cnt = 0, ir_n = 0, dr_n = 0, period_err = 0;
   logic [15:0] tms_log = '0;
   logic [4:0]  ir_cap = '0;
   logic [63:0] dr_sr = '0, dr_in = '0, tdo_word = '0;
   time         last_rise_t = 0;
   bit          rise_seen = 1'b0;

   jtag_dtm_sequencer #(.CLK_DIV(CLK_DIV), .IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_skip_ir(cmd_skip_ir), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_dr_len(cmd_dr_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .busy(busy),
      .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
   );

   always #5 clock = ~clock;

   function automatic int tap_next(input int s, input logic tms);
      case (s)
         T_TLR:   return tms ? T_TLR   : T_RTI;
         T_RTI:   return tms ? T_SELDR : T_RTI;
         T_SELDR: return tms ? T_SELIR : T_CAPDR;
         T_CAPDR: return tms ? T_EX1DR : T_SHDR;
         T_SHDR:  return tms ? T_EX1DR : T_SHDR;
         T_EX1DR: return tms ? T_UPDR  : T_PSDR;
         T_PSDR:  return tms ? T_EX2DR : T_PSDR;
         T_EX2DR: return tms ? T_UPDR  : T_SHDR;
         T_UPDR:  return tms ? T_SELDR : T_RTI;
         T_SELIR: return tms ? T_TLR   : T_CAPIR;
         T_CAPIR: return tms ? T_EX1IR : T_SHIR;
         T_SHIR:  return tms ? T_EX1IR : T_SHIR;
         T_EX1IR: return tms ? T_UPIR  : T_PSIR;
         T_PSIR:  return tms ? T_EX2IR : T_PSIR;
         T_EX2IR: return tms ? T_UPIR  : T_SHIR;
         T_UPIR:  return tms ? T_SELDR : T_RTI;
         default: return T_TLR;
      endcase
   endfunction

   // TAP target: act on TCK rise, present TDO on TCK fall
   always @(posedge jtag_TCK) begin
      rise_cnt <= rise_cnt + 1;
      if (rise_cnt < 16) tms_log[rise_cnt] <= jtag_TMS;
      if (rise_seen && (($time - last_rise_t) != PERIOD)) period_err <= period_err + 1;
      rise_seen   <= 1'b1;
      last_rise_t <= $time;
      case (tap_st)
         T_SHIR:  begin ir_cap <= {jtag_TDI, ir_cap[4:1]}; ir_n <= ir_n + 1; end
         T_SHDR:  begin
            if (dr_n < 64) dr_in[dr_n] <= jtag_TDI;
            dr_n  <= dr_n + 1;
            dr_sr <= dr_sr >> 1;
         end
         T_CAPDR: dr_sr <= tdo_word;
         default: ;
      endcase
      tap_st <= tap_next(tap_st, jtag_TMS);
   end

   always @(negedge jtag_TCK) jtag_TDO <= (tap_st == T_SHDR) ? dr_sr[0] : 1'b0;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_model();
      rise_cnt = 0; ir_n = 0; dr_n = 0; dr_in = '0; ir_cap = '0; tms_log = '0; rise_seen = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int i;
      for (i = 0; i < 2000 && !cmd_ready; i++) tick();
      if (!cmd_ready) check_value(tag, 64'd0, 64'd1);
   endtask

   task automatic check_tap_reset(input string tag);
      check_value({tag, "_rises"}, rise_cnt, 6);
      check_value({tag, "_tms"}, {58'd0, tms_log[5:0]}, 64'h1F);
      check_value({tag, "_tap"}, tap_st, T_RTI);
   endtask

   task automatic send_cmd(input bit skip, input logic [4:0] ir, input logic [DR_MAX-1:0] dr,
                           input int len, input logic [63:0] tdo);
      exp_t        e;
      int          eff;
      logic [63:0] m;
      eff        = (len > DR_MAX) ? DR_MAX : len;
      m          = (eff == 0) ? 64'd0 : ((64'd1 << eff) - 64'd1);
      e.rsp      = DR_MAX'(tdo & m);
      e.ir       = ir;
      e.dr_in    = {23'd0, dr} & m;
      e.len      = eff;
      e.irn      = skip ? 0 : IR_LEN;
      e.rises    = (skip ? 0 : 11) + ((eff > 0) ? 5 + eff : 0);
      e.skip     = skip;
      tdo_word   = tdo;
      cmd_skip_ir = skip; cmd_ir = ir; cmd_dr = dr; cmd_dr_len = LEN_W'(len);
      cmd_valid  = 1'b1;
      tick();
      cmd_valid  = 1'b0;
      cmd_ir     = ~ir; cmd_dr = ~dr; cmd_dr_len = ~cmd_dr_len; cmd_skip_ir = ~skip;
      clear_model();
      sb_q.push_back(e);
   endtask

   task automatic do_scan(input bit skip, input logic [4:0] ir, input logic [DR_MAX-1:0] dr,
                          input int len, input logic [63:0] tdo, input int hold);
      exp_t              e;
      int                i;
      logic [DR_MAX-1:0] snap;
      wait_ready("cmd_ready_timeout");
      send_cmd(skip, ir, dr, len, tdo);
      for (i = 0; i < 2000 && !rsp_valid; i++) tick();
      if (!rsp_valid) check_value("rsp_valid_timeout", 64'd0, 64'd1);
      snap = rsp_dr;
      for (i = 0; i < hold; i++) begin
         check_value("hold_rsp_valid", rsp_valid, 1);
         check_value("hold_rsp_dr", rsp_dr, snap);
         check_value("hold_tck", jtag_TCK, 0);
         check_value("hold_cmd_ready", cmd_ready, 0);
         tick();
      end
      e = sb_q.pop_front();
      check_value("rsp_dr", rsp_dr, e.rsp);
      check_value("tck_rises", rise_cnt, e.rises);
      check_value("ir_bits", ir_n, e.irn);
      if (!e.skip) check_value("ir_value", ir_cap, e.ir);
      check_value("dr_bits", dr_n, e.len);
      check_value("dr_tdi", dr_in, e.dr_in);
      check_value("tap_end", tap_st, T_RTI);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_value("idle_cmd_ready", cmd_ready, 1);
      check_value("idle_rsp_valid", rsp_valid, 0);
      check_value("idle_busy", busy, 0);
   endtask

   initial begin
      logic [63:0] r;
      int          i;
      repeat (3) tick();
      check_value("rst_tck", jtag_TCK, 0);
      check_value("rst_tms", jtag_TMS, 1);
      check_value("rst_tdi", jtag_TDI, 0);
      check_value("rst_cmd_ready", cmd_ready, 0);
      check_value("rst_rsp_valid", rsp_valid, 0);
      check_value("rst_rsp_dr", rsp_dr, 0);
      check_value("rst_busy", busy, 1);
      reset = 1'b0;
      clear_model();
      wait_ready("boot_timeout");
      check_tap_reset("boot");

      do_scan(1'b0, IR_IDCODE, '0, 32, 64'h2000_0913, 0);
      r = {$urandom(), $urandom()};
      do_scan(1'b1, IR_DMI, 41'h1_2345_6789_A, 41, r, 0);
      do_scan(1'b0, IR_DTMCS, 41'h0_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      r = {$urandom(), $urandom()};
      do_scan(1'b0, IR_DMI, DR_MAX'(r), 41, ~r, 20);
      r = {$urandom(), $urandom()};
      do_scan(1'b1, IR_DMI, DR_MAX'(r), 63, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      do_scan(1'b1, IR_DMI, 41'h1_5555_5555, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);

      // reset while DR_SHIFT is on bit 10
      wait_ready("abort_cmd_timeout");
      r = {$urandom(), $urandom()};
      send_cmd(1'b1, IR_DMI, DR_MAX'(r), 41, r);
      for (i = 0; i < 2000 && dr_n < 10; i++) tick();
      check_value("abort_reach_bit10", dr_n, 10);
      reset = 1'b1;
      clear_model();
      sb_q.delete();
      tick();
      check_value("abort_tck", jtag_TCK, 0);
      check_value("abort_rsp_valid", rsp_valid, 0);
      check_value("abort_cmd_ready", cmd_ready, 0);
      check_value("abort_tms", jtag_TMS, 1);
      reset = 1'b0;
      wait_ready("abort_recover_timeout");
      check_tap_reset("abort");

      r = {$urandom(), $urandom()};
      do_scan(1'b1, IR_DMI, DR_MAX'(r), 7, ~r, 0);
      check_value("tck_period_errors", period_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
